dm_port_arbiter: RTL
====================

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 SHALL have parameter DMA_SIZE, default 17, DM address width.
REQ-002 SHALL have parameter DMD_SIZE, default 16, DM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports r0_req / r1_req  input  1  access request from requester 0 (core) / 1 (DMA-debug).
REQ-006 SHALL have ports r0_RbW / r1_RbW  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports r0_a / r1_a  input  DMA_SIZE  request address.
REQ-008 SHALL have ports r0_wdata / r1_wdata  input  DMD_SIZE  write data.
REQ-009 SHALL have ports r0_gnt / r1_gnt  output  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports r0_rvalid / r1_rvalid  output  1  read data valid (registered).
REQ-011 SHALL have port rdata  output  DMD_SIZE  read return data, shared by both requesters.
REQ-012 SHALL have ports ps_dm_a_chipSelect, ps_dm_a_RbW  output  1 each; ps_dm_a  output  DMA_SIZE  to DM.
REQ-013 SHALL have port dmDataIn  output  DMD_SIZE  to DM; dmDataOut  input  DMD_SIZE  from DM.
REQ-014 SHALL have port init_done  output  1  high once priming is complete.

Function
REQ-015 SHALL implement FSM INIT_RD -> INIT_WAIT -> RUN; RUN is terminal until reset.
REQ-016 INIT_RD SHALL drive chipSelect=1, RbW=0, ps_dm_a=0 for one cycle; both gnt low.
REQ-017 INIT_WAIT SHALL load shadow register from dmDataOut, both gnt low; init_done rises on entry to RUN.
REQ-018 In RUN, a transfer SHALL occur in a cycle where rX_req && rX_gnt; requesters hold req/RbW/a/wdata until granted.
REQ-019 At most one gnt SHALL be high per cycle; lone request granted same cycle.
REQ-020 On simultaneous requests, grant SHALL go to the requester not granted last (round-robin pointer, reset value: favour r0).
REQ-021 Grant cycle N SHALL drive chipSelect=1, RbW and ps_dm_a from the winner; chipSelect=0 when no grant.
REQ-022 When chipSelect=0, ps_dm_a and ps_dm_a_RbW SHALL hold their last driven values.
REQ-023 A write granted in cycle N SHALL drive dmDataIn = that wdata (registered) throughout cycle N+1 (DM commits at N+1).
REQ-024 A read granted in cycle N SHALL assert the winner's rvalid in cycle N+1 with rdata = dmDataOut.
REQ-025 dmDataIn SHALL be: write-data register if cycle N-1 issued a write; else dmDataOut if N-1 issued a read; else shadow register.
REQ-026 Shadow register SHALL capture dmDataIn every cycle, so DM same-address bypass always returns the true contents of the last address driven.
REQ-027 Back-to-back accesses (write-then-read, read-then-read, same or different address, either requester) SHALL issue without bubbles.
REQ-028 Read and write SHALL never stall on each other; throughput = one access per cycle.

Reset
REQ-029 rst_n low SHALL immediately force: FSM=INIT_RD, all gnt/rvalid=0, chipSelect=0, RbW=0, ps_dm_a=0, dmDataIn=0, rdata=0, shadow=0, pointer->r0, init_done=0.
REQ-030 Reset asserted mid-transfer SHALL drop any pending rvalid or write-data drive; priming repeats after release.

Verification
REQ-031 Release rst_n, DM[0]=16'h1234 -> INIT_RD, INIT_WAIT, init_done high in 3rd cycle; gnt low until then.
REQ-032 r0 write a=0x0000A data 16'hFFEE, r1 read a=0x0000A next cycle -> r1_rvalid one cycle later, rdata=16'hFFEE.
REQ-033 r0 and r1 request reads continuously -> grants alternate r0,r1,r0,...; each rvalid matches its owner's address data.
REQ-034 Read a=0x00005 (DM=16'h00AB), idle 3 cycles, read a=0x00005 again -> both rdata=16'h00AB.
REQ-035 rst_n pulsed low during a write's N+1 cycle -> outputs at reset values asynchronously, FSM restarts at INIT_RD.
REQ-036 Read-then-read same address 0x00007 (DM=16'h5A5A) back-to-back -> both rdata=16'h5A5A.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory (DM); primes a shadow of DM[0] after reset.
// Latency: grant is combinational in the request cycle; rvalid/rdata and write data to DM follow one cycle after the grant.
// Backpressure: a losing requester holds its request until granted; one access per cycle, reads and writes never stall each other.
module dm_port_arbiter #(
    parameter int DMA_SIZE = 17,
    parameter int DMD_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r0_req,
    input  logic                r0_RbW,
    input  logic [DMA_SIZE-1:0] r0_a,
    input  logic [DMD_SIZE-1:0] r0_wdata,
    input  logic                r1_req,
    input  logic                r1_RbW,
    input  logic [DMA_SIZE-1:0] r1_a,
    input  logic [DMD_SIZE-1:0] r1_wdata,
    output logic                r0_gnt,
    output logic                r1_gnt,
    output logic                r0_rvalid,
    output logic                r1_rvalid,
    output logic [DMD_SIZE-1:0] rdata,
    output logic                ps_dm_a_chipSelect,
    output logic                ps_dm_a_RbW,
    output logic [DMA_SIZE-1:0] ps_dm_a,
    output logic [DMD_SIZE-1:0] dmDataIn,
    input  logic [DMD_SIZE-1:0] dmDataOut,
    output logic                init_done
);

    localparam logic [1:0] S_INIT_RD   = 2'd0;
    localparam logic [1:0] S_INIT_WAIT = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    logic [1:0]          state;
    logic                prio_r1;    // 1: r1 wins the next tie (r0 was granted last)
    logic [DMA_SIZE-1:0] a_q;        // last address driven to DM
    logic                rbw_q;      // last RbW driven to DM
    logic [DMD_SIZE-1:0] wdata_q;    // write data for the write issued last cycle
    logic                iss_q;      // an access was issued last cycle
    logic                iss_wr_q;   // the access issued last cycle was a write
    logic [DMD_SIZE-1:0] shadow_q;   // true contents of the last address driven
    logic                run;
    logic                init_rd;
    logic                any_gnt;
    logic [DMD_SIZE-1:0] win_wdata;

    assign run     = (state == S_RUN);
    assign init_rd = (state == S_INIT_RD);

    // Round-robin grant: a lone request wins outright, a tie goes to the side not granted last.
    assign r0_gnt  = run & r0_req & (~r1_req | ~prio_r1);
    assign r1_gnt  = run & r1_req & (~r0_req |  prio_r1);
    assign any_gnt = r0_gnt | r1_gnt;

    // The priming read happens in the first cycle after release; gating with rst_n
    // keeps the chip select quiet while reset is still asserted.
    assign ps_dm_a_chipSelect = (init_rd & rst_n) | any_gnt;

    // Drive the winner's command to DM; with no access the address/RbW hold their last values.
    always_comb begin
        ps_dm_a     = a_q;
        ps_dm_a_RbW = rbw_q;
        win_wdata   = r0_wdata;
        if (init_rd) begin
            ps_dm_a     = '0;
            ps_dm_a_RbW = 1'b0;
        end else if (r0_gnt) begin
            ps_dm_a     = r0_a;
            ps_dm_a_RbW = r0_RbW;
            win_wdata   = r0_wdata;
        end else if (r1_gnt) begin
            ps_dm_a     = r1_a;
            ps_dm_a_RbW = r1_RbW;
            win_wdata   = r1_wdata;
        end
    end

    // DM rewrites the last driven address every cycle, so dmDataIn must always carry its
    // true contents: fresh write data, the value just read, or the shadow copy when idle.
    always_comb begin
        if (iss_wr_q) begin
            dmDataIn = wdata_q;
        end else if (iss_q) begin
            dmDataIn = dmDataOut;
        end else begin
            dmDataIn = shadow_q;
        end
    end

    // Read return data is the DM output in the cycle after a read grant, zero otherwise.
    assign rdata     = (r0_rvalid | r1_rvalid) ? dmDataOut : '0;
    assign init_done = run;

    // Priming sequence: one read of address 0, one cycle to capture it, then run forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT_RD;
        end else begin
            case (state)
                S_INIT_RD:   state <= S_INIT_WAIT;
                S_INIT_WAIT: state <= S_RUN;
                S_RUN:       state <= S_RUN;
                default:     state <= S_INIT_RD;
            endcase
        end
    end

    // Round-robin pointer follows whichever requester was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r1 <= 1'b0;
        end else if (r0_gnt) begin
            prio_r1 <= 1'b1;
        end else if (r1_gnt) begin
            prio_r1 <= 1'b0;
        end
    end

    // Remember the last command driven so the DM port holds steady while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            rbw_q <= 1'b0;
        end else if (ps_dm_a_chipSelect) begin
            a_q   <= ps_dm_a;
            rbw_q <= ps_dm_a_RbW;
        end
    end

    // Track what was issued last cycle and keep the shadow copy of the last address current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q    <= 1'b0;
            iss_wr_q <= 1'b0;
            wdata_q  <= '0;
            shadow_q <= '0;
        end else begin
            iss_q    <= ps_dm_a_chipSelect;
            iss_wr_q <= any_gnt & ps_dm_a_RbW;
            if (any_gnt & ps_dm_a_RbW) begin
                wdata_q <= win_wdata;
            end
            shadow_q <= dmDataIn;
        end
    end

    // Read-valid flags mark the cycle in which each requester's read data is on rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= r0_gnt & ~r0_RbW;
            r1_rvalid <= r1_gnt & ~r1_RbW;
        end
    end

endmodule
